// File: rtl/audio_gain_if.sv
// Codec-side signal bundle for the soft-volume stage: record samples and frame strobe in,
// scaled play samples and gain status out.
interface audio_gain_if #(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 16
) ();
    logic              NewFrame;
    logic [DATA_W-1:0] LeftRecData;
    logic [DATA_W-1:0] RightRecData;
    logic [GAIN_W-1:0] target_gain;
    logic              mute;
    logic [DATA_W-1:0] LeftPlayData;
    logic [DATA_W-1:0] RightPlayData;
    logic [GAIN_W-1:0] cur_gain;
    logic              ramping;
    logic              clip;
    logic              sample_valid;

    modport master (
        output NewFrame, LeftRecData, RightRecData, target_gain, mute,
        input  LeftPlayData, RightPlayData, cur_gain, ramping, clip, sample_valid
    );

    modport slave (
        input  NewFrame, LeftRecData, RightRecData, target_gain, mute,
        output LeftPlayData, RightPlayData, cur_gain, ramping, clip, sample_valid
    );
endinterface

// File: rtl/audio_gain_stage.sv
// Soft-volume stage: once per frame scales both record samples by a shared gain that ramps
// toward the target in fixed steps, saturating the results onto the play outputs.
//
// state    | meaning
// S_IDLE   | wait for frame strobe rise; capture samples, gain and target
// S_MUL_L  | left product through shared multiplier into holding register
// S_MUL_R  | right product through shared multiplier into holding register
// S_UPDATE | publish play data and clip, pulse sample_valid, step gain
module audio_gain_stage #(
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int FRAC      = 14,
    parameter int RAMP_STEP = 64
) (
    input logic         audio_clk,
    input logic         reset,
    audio_gain_if.slave bus
);
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam logic signed [GAIN_W:0] STEP_S = (GAIN_W + 1)'(RAMP_STEP);
    localparam logic [GAIN_W-1:0]      STEP_G = GAIN_W'(RAMP_STEP);

    typedef enum logic [1:0] {S_IDLE, S_MUL_L, S_MUL_R, S_UPDATE} state_t;

    state_t r_state;
    state_t w_next;

    logic              r_nf_d;
    logic              w_trig;
    logic [DATA_W-1:0] r_cap_l;
    logic [DATA_W-1:0] r_cap_r;
    logic [GAIN_W-1:0] r_g;
    logic [GAIN_W-1:0] r_eff;
    logic [GAIN_W-1:0] r_cur;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic              r_sat_l;
    logic              r_sat_r;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_right;
    logic              r_clip;
    logic              r_valid;

    logic [DATA_W-1:0]        w_mul_a;
    logic signed [PW-1:0]     w_prod;
    logic [PW-DATA_W-FRAC:0]  w_hi;
    logic                     w_ovf;
    logic [DATA_W-1:0]        w_res;
    logic signed [GAIN_W:0]   w_diff;
    logic [GAIN_W-1:0]        w_gain_next;

    assign w_trig = bus.NewFrame & ~r_nf_d;

    always_ff @(posedge audio_clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_trig) w_next = S_MUL_L;
            S_MUL_L:  w_next = S_MUL_R;
            S_MUL_R:  w_next = S_UPDATE;
            S_UPDATE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Single multiplier shared between channels; gain is zero-extended so it stays unsigned.
    assign w_mul_a = (r_state == S_MUL_R) ? r_cap_r : r_cap_l;
    assign w_prod  = $signed({{(GAIN_W + 1){w_mul_a[DATA_W-1]}}, w_mul_a})
                   * $signed({{DATA_W{1'b0}}, 1'b0, r_g});

    // Dropping the low FRAC bits of a two's-complement value floors toward minus infinity.
    assign w_hi  = w_prod[PW-1:DATA_W-1+FRAC];
    assign w_ovf = ~((&w_hi) | ~(|w_hi));
    assign w_res = !w_ovf          ? w_prod[DATA_W-1+FRAC:FRAC] :
                   w_prod[PW-1]    ? {1'b1, {(DATA_W - 1){1'b0}}} :
                                     {1'b0, {(DATA_W - 1){1'b1}}};

    assign w_diff = $signed({1'b0, r_eff}) - $signed({1'b0, r_cur});

    always_comb begin
        w_gain_next = r_eff;
        if (w_diff > STEP_S)       w_gain_next = r_cur + STEP_G;
        else if (w_diff < -STEP_S) w_gain_next = r_cur - STEP_G;
    end

    always_ff @(posedge audio_clk or negedge reset) begin
        if (!reset) begin
            r_nf_d   <= 1'b0;
            r_cap_l  <= '0;
            r_cap_r  <= '0;
            r_g      <= '0;
            r_eff    <= '0;
            r_cur    <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_sat_l  <= 1'b0;
            r_sat_r  <= 1'b0;
            r_left   <= '0;
            r_right  <= '0;
            r_clip   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_nf_d  <= bus.NewFrame;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_cap_l <= bus.LeftRecData;
                        r_cap_r <= bus.RightRecData;
                        r_g     <= r_cur;
                        r_eff   <= bus.mute ? '0 : bus.target_gain;
                    end
                end
                S_MUL_L: begin
                    r_hold_l <= w_res;
                    r_sat_l  <= w_ovf;
                end
                S_MUL_R: begin
                    r_hold_r <= w_res;
                    r_sat_r  <= w_ovf;
                end
                S_UPDATE: begin
                    r_left  <= r_hold_l;
                    r_right <= r_hold_r;
                    r_clip  <= r_sat_l | r_sat_r;
                    r_valid <= 1'b1;
                    r_cur   <= w_gain_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.LeftPlayData  = r_left;
    assign bus.RightPlayData = r_right;
    assign bus.cur_gain      = r_cur;
    assign bus.clip          = r_clip;
    assign bus.sample_valid  = r_valid;
    assign bus.ramping       = (r_cur != (bus.mute ? '0 : bus.target_gain));
endmodule

// File: tb/tb_audio_gain_stage.sv
// Directed bench for audio_gain_stage: gain ramps, unity, saturation, truncation, mute and
// reset-abort cases with hand-computed expectations.
module tb_audio_gain_stage;
    logic audio_clk = 1'b0;
    logic reset     = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int nvalid;
    int vidx;

    audio_gain_if bus ();

    audio_gain_stage dut (
        .audio_clk (audio_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One frame: NewFrame high for 4 edges then low for 4; records sample_valid pulses.
    task automatic frame(input logic [23:0] l, input logic [23:0] r);
        @(negedge audio_clk);
        bus.NewFrame     = 1'b1;
        bus.LeftRecData  = l;
        bus.RightRecData = r;
        nvalid = 0;
        vidx   = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge audio_clk);
            #1;
            if (bus.sample_valid) begin
                nvalid++;
                if (vidx == 0) vidx = i;
            end
            if (i == 4) bus.NewFrame = 1'b0;
        end
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame(24'h100000, 24'h100000);
    endtask

    initial begin
        bus.NewFrame     = 1'b0;
        bus.LeftRecData  = '0;
        bus.RightRecData = '0;
        bus.target_gain  = 16'h4000;
        bus.mute         = 1'b0;
        repeat (3) @(negedge audio_clk);
        chk("rst_left", 32'(bus.LeftPlayData), 32'h0);
        chk("rst_gain", 32'(bus.cur_gain), 32'h0);
        chk("rst_valid", 32'(bus.sample_valid), 32'h0);
        reset = 1'b1;

        // Startup ramp
        frame(24'h100000, 24'h100000);
        chk("start_f1_left", 32'(bus.LeftPlayData), 32'h0);
        chk("start_f1_gain", 32'(bus.cur_gain), 32'd64);
        chk("start_f1_nvalid", 32'(nvalid), 32'd1);
        frames(254);
        chk("start_f255_gain", 32'(bus.cur_gain), 32'h3FC0);
        chk("start_f255_ramping", 32'(bus.ramping), 32'h1);
        frame(24'h100000, 24'h100000);
        chk("start_f256_gain", 32'(bus.cur_gain), 32'h4000);
        chk("start_f256_ramping", 32'(bus.ramping), 32'h0);

        // Unity pass-through with exact latency
        frame(24'h123456, 24'hFEDCBA);
        chk("unity_left", 32'(bus.LeftPlayData), 32'h123456);
        chk("unity_right", 32'(bus.RightPlayData), 32'hFEDCBA);
        chk("unity_clip", 32'(bus.clip), 32'h0);
        chk("unity_latency", 32'(vidx), 32'd4);
        chk("unity_nvalid", 32'(nvalid), 32'd1);

        // Saturation at gain 2.0
        bus.target_gain = 16'h8000;
        frames(256);
        chk("sat_gain", 32'(bus.cur_gain), 32'h8000);
        frame(24'h600000, 24'hA00000);
        chk("sat_left", 32'(bus.LeftPlayData), 32'h7FFFFF);
        chk("sat_right", 32'(bus.RightPlayData), 32'h800000);
        chk("sat_clip", 32'(bus.clip), 32'h1);
        frame(24'h100000, 24'h100000);
        chk("x2_left", 32'(bus.LeftPlayData), 32'h200000);
        chk("x2_right", 32'(bus.RightPlayData), 32'h200000);
        chk("x2_clip", 32'(bus.clip), 32'h0);

        // Truncation toward minus infinity at gain 0.5
        bus.target_gain = 16'h2000;
        frames(384);
        chk("half_gain", 32'(bus.cur_gain), 32'h2000);
        frame(24'hFFFFFF, 24'h000003);
        chk("trunc_left", 32'(bus.LeftPlayData), 32'hFFFFFF);
        chk("trunc_right", 32'(bus.RightPlayData), 32'h000001);

        // Mute ramp down, then small target without overshoot
        bus.target_gain = 16'h4000;
        frames(128);
        chk("pre_mute_gain", 32'(bus.cur_gain), 32'h4000);
        bus.mute = 1'b1;
        frame(24'h123456, 24'h123456);
        chk("mute_f1_gain", 32'(bus.cur_gain), 32'h3FC0);
        frames(255);
        chk("mute_end_gain", 32'(bus.cur_gain), 32'h0);
        chk("mute_end_ramping", 32'(bus.ramping), 32'h0);
        frame(24'h123456, 24'hEDCBA9);
        chk("mute_left", 32'(bus.LeftPlayData), 32'h0);
        chk("mute_right", 32'(bus.RightPlayData), 32'h0);
        bus.mute        = 1'b0;
        bus.target_gain = 16'h0050;
        frame(24'h400000, 24'h400000);
        chk("small_f1_gain", 32'(bus.cur_gain), 32'h0040);
        frame(24'h400000, 24'h400000);
        chk("small_f2_gain", 32'(bus.cur_gain), 32'h0050);
        frame(24'h400000, 24'hC00000);
        chk("small_f3_gain", 32'(bus.cur_gain), 32'h0050);
        chk("small_left", 32'(bus.LeftPlayData), 32'h005000);
        chk("small_right", 32'(bus.RightPlayData), 32'hFFB000);

        // Reset two cycles after trig aborts the frame
        @(negedge audio_clk);
        bus.NewFrame     = 1'b1;
        bus.LeftRecData  = 24'h400000;
        bus.RightRecData = 24'h400000;
        @(negedge audio_clk);
        @(negedge audio_clk);
        reset = 1'b0;
        #1;
        chk("abort_left", 32'(bus.LeftPlayData), 32'h0);
        chk("abort_right", 32'(bus.RightPlayData), 32'h0);
        chk("abort_gain", 32'(bus.cur_gain), 32'h0);
        nvalid = 0;
        bus.target_gain  = 16'h4000;
        bus.LeftRecData  = 24'h100000;
        bus.RightRecData = 24'h100000;
        for (int i = 0; i < 3; i++) begin
            @(posedge audio_clk);
            #1;
            if (bus.sample_valid) nvalid++;
        end
        chk("abort_nvalid", 32'(nvalid), 32'd0);

        // NewFrame still high at release counts as a rise
        @(negedge audio_clk);
        reset  = 1'b1;
        nvalid = 0;
        vidx   = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge audio_clk);
            #1;
            if (bus.sample_valid) begin
                nvalid++;
                if (vidx == 0) vidx = i;
            end
            if (i == 4) bus.NewFrame = 1'b0;
        end
        chk("release_nvalid", 32'(nvalid), 32'd1);
        chk("release_latency", 32'(vidx), 32'd4);
        chk("release_gain", 32'(bus.cur_gain), 32'd64);
        frame(24'h100000, 24'hF00000);
        chk("post_left", 32'(bus.LeftPlayData), 32'h001000);
        chk("post_right", 32'(bus.RightPlayData), 32'hFFF000);
        chk("post_gain", 32'(bus.cur_gain), 32'd128);
        chk("post_nvalid", 32'(nvalid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/audio_gain_stage.md
Name: audio_gain_stage

Overview:
- Soft-volume stage between codec port capture and playback paths.
- Once per frame, on NewFrame, captures the 24-bit left/right record samples and scales both by a shared ramped gain, saturating the results.
- Drives LeftPlayData/RightPlayData, which stay stable until the codec port loads them at the next frame start.
- The gain ramps toward the target one step per frame to avoid zipper noise. Mute ramps the gain to zero.

Parameters:
DATA_W, 24, sample width (two's complement)
GAIN_W, 16, gain width (unsigned)
FRAC, 14, gain fractional bits (0x4000 = unity, max ~3.99)
RAMP_STEP, 64, gain change per frame while ramping

Ports:
audio_clk  in  1  codec master clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
NewFrame  in  1  frame strobe from codec port, level-high for 4 audio_clk cycles
LeftRecData  in  DATA_W  left record sample
RightRecData  in  DATA_W  right record sample
target_gain  in  GAIN_W  requested gain, Q2.14
mute  in  1  1 = effective target forced to 0
LeftPlayData  out  DATA_W  scaled left sample, registered
RightPlayData  out  DATA_W  scaled right sample, registered
cur_gain  out  GAIN_W  gain currently applied
ramping  out  1  1 while cur_gain != effective target
clip  out  1  1 if either channel saturated in last processed frame
sample_valid  out  1  one-cycle pulse when play outputs update

Behaviour:
Reset (reset=0, asynchronous):
- All outputs go to 0, including cur_gain. The stage ramps up from silence after release.
- FSM goes to IDLE. The edge register nf_d goes to 0.

Edge detect:
- trig = NewFrame & ~nf_d; nf_d follows NewFrame every cycle.
- A 4-cycle NewFrame level yields exactly one trig.
- NewFrame already high at reset release counts as a rise.

FSM states IDLE -> MUL_L -> MUL_R -> UPDATE -> IDLE, one cycle each:
- IDLE:
  - On trig, latch LeftRecData and RightRecData into capture registers.
  - Latch g = cur_gain.
  - Latch eff_target = mute ? 0 : target_gain.
- MUL_L: one shared signed multiplier computes the left product; result goes to a holding register.
- MUL_R: same multiplier computes the right product.
- UPDATE:
  - Write LeftPlayData, RightPlayData and clip.
  - Pulse sample_valid.
  - Step cur_gain.
- trig outside IDLE is ignored; this cannot occur with frames 256 cycles apart.

Latency and timing:
- Play outputs change on the 4th rising edge after the trig cycle.
- This is well inside the 24-cycle window before the codec port's ld.

Arithmetic:
- Product = signed(sample) * {0, g}, 41 bits.
- Arithmetic shift right by FRAC, which truncates toward minus infinity.
- Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. 0x800000..0x7FFFFF.
- clip = 1 if either channel saturated. Held until the next UPDATE.

Ramp, at UPDATE:
- diff = eff_target - cur_gain.
- If |diff| <= RAMP_STEP, cur_gain = eff_target.
- Otherwise cur_gain moves RAMP_STEP toward the target. No overshoot, no wrap below 0 or above 0xFFFF.
- Frame N always uses the pre-step gain.
- Target or mute changes are sampled only at trig. Direction is re-evaluated every frame.
- ramping = (cur_gain != (mute ? 0 : target_gain)), combinational from current inputs.

Reset mid-operation:
- Processing aborts.
- No sample_valid is issued.
- Outputs stay 0 until a post-release frame completes.

Test Plan:
1. Startup ramp:
   - Stimulus: release reset, target_gain=0x4000, NewFrame every 256 cycles.
   - Required: frame 1 outputs 0 with cur_gain=64 after it; cur_gain=0x4000 after frame 256; ramping drops to 0 at that UPDATE.
2. Unity pass-through:
   - Stimulus: cur_gain=0x4000, L=0x123456, R=0xFEDCBA.
   - Required: outputs equal the inputs exactly 4 cycles after the trig cycle; a single sample_valid pulse; clip=0.
3. Saturation:
   - Stimulus: target and cur at 0x8000 (2.0), L=0x600000, R=0xA00000.
   - Required: L out=0x7FFFFF, R out=0x800000, clip=1.
   - Then L=R=0x100000 gives 0x200000 on both and clip=0.
4. Truncation:
   - Stimulus: gain 0x2000 (0.5), L=0xFFFFFF (-1), R=0x000003.
   - Required: L out=0xFFFFFF, R out=0x000001.
5. Mute ramp:
   - Stimulus: from cur_gain=0x4000, mute=1.
   - Required: cur_gain decrements by 64 per frame and reaches 0 after 256 frames; outputs then 0.
   - Stimulus: mute=0 with target 0x0050.
   - Required: cur_gain=0x40 after frame 1, 0x50 after frame 2 with no overshoot.
6. Edge and reset robustness:
   - Stimulus: hold NewFrame high for 4 cycles.
   - Required: exactly one sample_valid.
   - Stimulus: assert reset 2 cycles after trig.
   - Required: all outputs 0 at once, no sample_valid; the next post-release frame processes normally.
